html_char_streamer: RTL and testbench

- Source end of the parser character interface: fetches HTML document bytes from a synchronous-read ROM and presents one char per cycle to html_parser.
- Advances only on cycles where the parser's out_pause is low, and drives the parser's state_enable.
- Detects end of document (terminator byte or length limit) and drops state_enable cleanly, without handing the terminator to the parser as text.

---
 rtl/html_char_streamer.sv | 84 ++++++++
 tb/tb_html_char_streamer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/html_char_streamer.sv
// Streams a NUL/length-terminated document out of a synchronous-read ROM
// into the parser's character interface, one char per un-paused cycle.
module html_char_streamer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DOC_LENGTH = 4096,
  parameter int CHAR_WIDTH = 8,
  parameter logic [CHAR_WIDTH-1:0] TERMINATOR = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] doc_base,
  input  logic                  pause,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [CHAR_WIDTH-1:0] mem_data,
  output logic [CHAR_WIDTH-1:0] char,
  output logic                  state_enable,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   char_count
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] DOC_LEN = (ADDR_WIDTH+1)'(DOC_LENGTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  head_end;
  logic                  advance;
  logic                  in_stream;

  assign in_stream = (state_q == STREAM);
  assign head_end  = (mem_data == TERMINATOR) || (ptr_q == DOC_LEN);
  assign advance   = in_stream && !pause && !head_end;

  // Look one address ahead on consuming cycles so the ROM's read latency
  // never inserts a bubble between consecutive chars.
  assign mem_addr = base_q + ADDR_WIDTH'(ptr_q + {{ADDR_WIDTH{1'b0}}, advance});

  assign char         = (in_stream && !head_end) ? mem_data : '0;
  assign state_enable = in_stream && !(head_end && !pause);
  assign busy         = (state_q == PRIME) || in_stream;
  assign done         = (state_q == DONE);
  assign char_count   = ptr_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    base_d  = base_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = PRIME;
          base_d  = doc_base;
          ptr_d   = '0;
        end
      end
      PRIME:  state_d = STREAM;
      STREAM: begin
        if (advance) begin
          ptr_d = ptr_q + (ADDR_WIDTH+1)'(1);
        end else if (!pause) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: tb/tb_html_char_streamer.sv
// Randomised and directed checks of html_char_streamer against a document-level
// model: the expected char list is read straight out of the ROM image.
module tb_html_char_streamer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_m, start_l;
  logic [11:0] doc_base;
  logic        pause;
  logic [11:0] addr_m, addr_l;
  logic [7:0]  data_m, data_l;
  logic [7:0]  char_m, char_l;
  logic        se_m, se_l, busy_m, busy_l, done_m, done_l;
  logic [12:0] cnt_m, cnt_l;

  logic [7:0]  rom [4096];
  logic        sel;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) data_m <= rom[addr_m];
  always @(posedge clock) data_l <= rom[addr_l];

  html_char_streamer dut (
    .clock(clock), .reset(reset), .start(start_m), .doc_base(doc_base),
    .pause(pause), .mem_addr(addr_m), .mem_data(data_m), .char(char_m),
    .state_enable(se_m), .busy(busy_m), .done(done_m), .char_count(cnt_m)
  );

  html_char_streamer #(.DOC_LENGTH(4)) dut_lim (
    .clock(clock), .reset(reset), .start(start_l), .doc_base(doc_base),
    .pause(pause), .mem_addr(addr_l), .mem_data(data_l), .char(char_l),
    .state_enable(se_l), .busy(busy_l), .done(done_l), .char_count(cnt_l)
  );

  wire [7:0]  o_char = sel ? char_l : char_m;
  wire [11:0] o_addr = sel ? addr_l : addr_m;
  wire        o_se   = sel ? se_l   : se_m;
  wire        o_busy = sel ? busy_l : busy_m;
  wire        o_done = sel ? done_l : done_m;
  wire [12:0] o_cnt  = sel ? cnt_l  : cnt_m;

  task automatic put_str(input logic [11:0] b, input string s, input bit term);
    for (int i = 0; i < s.len(); i++) rom[b + 12'(i)] = s[i];
    if (term) rom[b + 12'(s.len())] = 8'h00;
  endtask

  // mode: 0 never pause, 1 random pause, 2 pause every other cycle.
  // Additionally pause for pause_n cycles while the model index equals pause_at.
  task automatic run_doc(input string name, input logic [11:0] b, input int limit,
                         input bit use_lim, input int mode, input int pause_at,
                         input int pause_n);
    logic [7:0] exp_q[$];
    logic [7:0] exp_char;
    logic [11:0] exp_addr;
    int k = 0, held = 0, len;
    bit ended = 0, tog = 0;
    for (int i = 0; i < limit; i++) begin
      if (rom[b + 12'(i)] == 8'h00) break;
      exp_q.push_back(rom[b + 12'(i)]);
    end
    len = exp_q.size();
    sel = use_lim;
    @(negedge clock);
    doc_base = b; pause = 1'bx;
    if (use_lim) start_l = 1'b1; else start_m = 1'b1;
    @(negedge clock);
    start_m = 1'b0; start_l = 1'b0; doc_base = 12'hABC;
    #1;
    checks++;
    if (o_busy !== 1'b1 || o_se !== 1'b0 || o_addr !== b || o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s prime: busy=%b se=%b addr=%h done=%b, want busy=1 se=0 addr=%h done=0",
               name, o_busy, o_se, o_addr, o_done, b);
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clock);
      if (k == pause_at && held < pause_n) begin
        pause = 1'b1; held++;
      end else if (mode == 1) pause = 1'($urandom_range(0, 1));
      else if (mode == 2) begin pause = tog; tog = ~tog; end
      else pause = 1'b0;
      #1;
      exp_char = (k < len) ? exp_q[k] : 8'h00;
      exp_addr = b + 12'(k) + 12'((!pause && k < len) ? 1 : 0);
      checks++;
      if (o_char !== exp_char || o_se !== !(k == len && !pause) || o_addr !== exp_addr ||
          o_cnt !== 13'(k) || o_busy !== 1'b1 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL %s stream k=%0d pause=%b: char=%h se=%b addr=%h cnt=%0d busy=%b done=%b, want char=%h se=%b addr=%h cnt=%0d busy=1 done=0",
                 name, k, pause, o_char, o_se, o_addr, o_cnt, o_busy, o_done,
                 exp_char, !(k == len && !pause), exp_addr, k);
      end
      if (!pause && k == len) begin ended = 1; break; end
      if (!pause) k++;
    end
    @(negedge clock);
    pause = 1'bx;
    #1;
    checks++;
    if (!ended || o_done !== 1'b1 || o_busy !== 1'b0 || o_se !== 1'b0 ||
        o_cnt !== 13'(len) || o_char !== 8'h00) begin
      errors++;
      $display("FAIL %s end: ended=%b done=%b busy=%b se=%b cnt=%0d char=%h, want ended=1 done=1 busy=0 se=0 cnt=%0d char=00",
               name, ended, o_done, o_busy, o_se, o_cnt, o_char, len);
    end
    $display("doc %s base=%h len=%0d chars_seen=%0d", name, b, len, k);
  endtask

  task automatic test_reset();
    reset = 1'b1; start_m = 1'b0; start_l = 1'b0; pause = 1'bx; doc_base = 12'h123;
    sel = 1'b0;
    repeat (2) @(negedge clock);
    start_m = 1'b1;
    @(negedge clock);
    reset = 1'b0; start_m = 1'b0;
    #1;
    checks++;
    if (se_m !== 1'b0 || busy_m !== 1'b0 || done_m !== 1'b0 || char_m !== 8'h00 ||
        addr_m !== 12'h000 || cnt_m !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: se=%b busy=%b done=%b char=%h addr=%h cnt=%0d, want all zero",
               se_m, busy_m, done_m, char_m, addr_m, cnt_m);
    end
    @(negedge clock);
    checks++;
    if (busy_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: busy=%b, want 0", busy_m);
    end
    $display("reset checked");
  endtask

  task automatic test_random_docs();
    for (int it = 0; it < 6; it++) begin
      logic [11:0] b = 12'($urandom_range(1000, 3000));
      int l = $urandom_range(0, 12);
      for (int i = 0; i < l; i++) rom[b + 12'(i)] = 8'($urandom_range(1, 255));
      rom[b + 12'(l)] = 8'h00;
      run_doc("random", b, 4096, 1'b0, (it % 2) + 1, -1, 0);
    end
  endtask

  task automatic test_reset_mid();
    string s = "hello";
    put_str(12'd200, s, 1'b1);
    sel = 1'b0;
    @(negedge clock);
    doc_base = 12'd200; start_m = 1'b1; pause = 1'b0;
    @(negedge clock);
    start_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      start_m = (k == 1); doc_base = 12'd700;
      #1;
      checks++;
      if (char_m !== s[k] || cnt_m !== 13'(k) || se_m !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_stream k=%0d: char=%h cnt=%0d se=%b, want char=%h cnt=%0d se=1",
                 k, char_m, cnt_m, se_m, s[k], k);
      end
    end
    start_m = 1'b0; reset = 1'b1;
    @(negedge clock);
    checks++;
    if (se_m !== 1'b0 || busy_m !== 1'b0 || cnt_m !== 13'd0 || done_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: se=%b busy=%b cnt=%0d done=%b, want 0 0 0 0",
               se_m, busy_m, cnt_m, done_m);
    end
    reset = 1'b0;
    $display("reset mid-stream checked");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h2e;
    test_reset();
    put_str(12'h000, "<p>ab</p>", 1'b1);
    run_doc("basic", 12'h000, 4096, 1'b0, 0, -1, 0);
    run_doc("pause_hold", 12'h000, 4096, 1'b0, 0, 3, 5);
    run_doc("pause_at_term", 12'h000, 4096, 1'b0, 0, 9, 3);
    put_str(12'd100, "abcdefg", 1'b0);
    run_doc("length_limit", 12'd100, 4, 1'b1, 0, -1, 0);
    run_doc("length_limit_rnd", 12'd100, 4, 1'b1, 1, -1, 0);
    test_random_docs();
    test_reset_mid();
    rom[12'hFFE] = "x"; rom[12'hFFF] = "y"; rom[12'h000] = 8'h00;
    run_doc("addr_wrap", 12'hFFE, 4096, 1'b0, 0, -1, 0);
    run_doc("empty_doc", 12'h000, 4096, 1'b0, 0, -1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
